// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
// Shared types and defaults for the APB master arbiter slice.
//   apb_state_e : APB master sequencing states (IDLE / SETUP / ACCESS)
//   DEF_*       : default parameter values for the arbiter and its sub-blocks
//   idx_width() : index width needed to address n requesters (minimum 1)
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// last_grant and wraps, so the most recently served requester has lowest
// priority. Also used by the AXI4-Lite request side.
// Ports:
//   req        [NUM_REQ]  request vector
//   last_grant [IDX_W]    index of the most recent accepted grant
//   enable     [1]        arbitration allowed this cycle; grant is 0 otherwise
//   grant      [NUM_REQ]  one-hot grant (0 when no request or disabled)
//   grant_idx  [IDX_W]    index of the granted requester (0 when no grant)
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // one extra bit so last_grant + offset cannot overflow before the wrap
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // rotate through the requesters after last_grant and take the first one set
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_s = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (enable && !found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Shares one APB4 master port between NUM_REQ requesters: round-robin
// arbitration, SETUP/ACCESS sequencing, and return of read data / error
// status to the requester that owns the transfer. One transfer at a time.
// Optional feature macro: APB_ARB_TIMEOUT_EN (ACCESS wait limit of
// TIMEOUT_CYCLES; without it ACCESS waits for pready indefinitely).
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready/req_write [NUM_REQ]  per-requester handshake, ready is combinational one-hot
//   req_addr/req_wdata/req_strb/req_prot     packed per requester (requester i at slice i)
//   rsp_valid [NUM_REQ] one-cycle completion pulse, rsp_rdata, rsp_slverr
//   pselx, penable, pwrite, paddr, pwdata, pstrb, pprot  registered APB outputs
//   prdata, pready, pslverr                              APB inputs
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int dataWidth      = DEF_DATA_WIDTH,
    parameter int addrWidth      = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
    input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
    input  logic [NUM_REQ*(dataWidth/8)-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]           req_prot,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [dataWidth-1:0]           rsp_rdata,
    output logic                           rsp_slverr,
    output logic                           pselx,
    output logic                           penable,
    output logic                           pwrite,
    output logic [addrWidth-1:0]           paddr,
    output logic [dataWidth-1:0]           pwdata,
    output logic [dataWidth/8-1:0]         pstrb,
    output logic [2:0]                     pprot,
    input  logic [dataWidth-1:0]           prdata,
    input  logic                           pready,
    input  logic                           pslverr
);

    localparam int STRB_W = dataWidth / 8;
    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_REQ = NUM_REQ'(1);

    apb_state_e       state_r;
    apb_state_e       next_state_s;
    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W-1:0] owner_r;
    logic [IDX_W-1:0] grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic             arb_point_s;
    logic             accept_s;
    logic             complete_s;
    logic             timeout_s;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [WAIT_W-1:0] wait_cnt_r;

    // ACCESS wait counter: cleared in SETUP, counts ACCESS cycles without pready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ACCESS) && !pready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout_s = (state_r == ACCESS) && !pready &&
                       (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES));
`else
    // no wait limit in this build; TIMEOUT_CYCLES is a non-negative count so this is 0
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    // a timed-out ACCESS ends exactly like a normal completion
    assign complete_s = (state_r == ACCESS) && (pready || timeout_s);

    // arbitration is allowed when idle or when the current transfer finishes;
    // gating with rst keeps req_ready low while reset is held
    assign arb_point_s = rst && ((state_r == IDLE) || complete_s);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .enable     (arb_point_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; a grant at completion goes straight to SETUP (no idle gap)
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = SETUP;
                else          next_state_s = IDLE;
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                if (complete_s) begin
                    if (accept_s) next_state_s = SETUP;
                    else          next_state_s = IDLE;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // round-robin pointer and transfer owner, updated only on an accepted grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            owner_r      <= '0;
        end else if (accept_s) begin
            last_grant_r <= grant_idx_s;
            owner_r      <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
            owner_r      <= owner_r;
        end
    end

    // APB bus registers: the accepted request is latched straight into them and
    // held unchanged through SETUP/ACCESS and while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pselx   <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= 3'b000;
        end else begin
            pselx   <= (next_state_s != IDLE);
            penable <= (next_state_s == ACCESS);
            if (accept_s) begin
                pwrite <= req_write[grant_idx_s];
                paddr  <= req_addr[int'(grant_idx_s)*addrWidth +: addrWidth];
                pwdata <= req_wdata[int'(grant_idx_s)*dataWidth +: dataWidth];
                pstrb  <= req_write[grant_idx_s] ?
                          req_strb[int'(grant_idx_s)*STRB_W +: STRB_W] : {STRB_W{1'b0}};
                pprot  <= req_prot[int'(grant_idx_s)*3 +: 3];
            end else begin
                pwrite <= pwrite;
                paddr  <= paddr;
                pwdata <= pwdata;
                pstrb  <= pstrb;
                pprot  <= pprot;
            end
        end
    end

    // response registers: one-cycle pulse to the owner after completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else if (complete_s) begin
            rsp_valid  <= ONE_REQ << owner_r;
            // writes and timed-out transfers return zero data
            rsp_rdata  <= (pwrite || !pready) ? {dataWidth{1'b0}} : prdata;
            rsp_slverr <= pready ? pslverr : 1'b1;
        end else begin
            rsp_valid  <= '0;
            rsp_rdata  <= rsp_rdata;
            rsp_slverr <= rsp_slverr;
        end
    end

endmodule
